alu_accumulator: RTL
====================

Name: alu_accumulator

Overview:
- Execution stage downstream of the instruction-cycle FSM. Consumes its IR, IBR, MBR and one-cycle Exec strobe; owns the accumulator AR and the 4-bit Flags register, both fed back to the FSM.
- AR supplies store data and addresses. Flags are tested by the conditional jumps.
- Adds a sticky illegal-opcode flag and a retired-instruction counter for debug.

Parameters:
- DATA_WIDTH, 8, width of AR, MBR, IBR and the operands.
- INST_WIDTH, 8, width of IR.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-high
- Exec  in  1  one-cycle execute strobe from the FSM
- IR  in  INST_WIDTH  current opcode; stable while Exec=1
- IBR  in  DATA_WIDTH  immediate operand
- MBR  in  DATA_WIDTH  memory operand, already valid when Exec=1
- AR  out  DATA_WIDTH  accumulator (registered)
- Flags  out  4  registered; [0]=ZERO, [1]=CARRY, [2]=NEG, [3]=OV (same order as the defines)
- err_illegal  out  1  sticky: Exec was seen with an undefined opcode
- retired  out  CNT_WIDTH  count of Exec strobes carrying a defined opcode

Behaviour:
- Reset (arst=1, async): AR=0, Flags=0, err_illegal=0, retired=0. Reset during any cycle, including one with Exec=1, discards that operation.
- Exec=0: every register holds. IR, IBR and MBR are ignored.
- Latency: Exec sampled high at edge N → AR, Flags and retired reflect the result after edge N. Zero-latency feedback is not required. The FSM only tests Flags on a later Exec.
- Opcode classes (IR, defined in defines.v):
  - 8'b000000_01 LOAD_X: AR=MBR.
  - 8'b000000_10 LOAD_I: AR=IBR.
  - 8'b010000xx arithmetic using MBR.
  - 8'b010001xx arithmetic using IBR.
  - 8'b100000xx logic using MBR.
  - 8'b100001xx logic using IBR.
  - 8'b110000xx shift/rotate on AR (operand ignored).
  - STORE_X, STORE_I and JMP/JZ/JC/JN/JV are defined no-ops here: counted as retired, AR and Flags unchanged.
- Arithmetic, IR[1:0]: 00 ADD, 01 SUB, 10 ADDC, 11 SUBC.
  - ADD: {c,r} = AR + op.
  - ADDC: {c,r} = AR + op + CARRY.
  - SUB: r = AR - op; c=1 on borrow (AR < op unsigned).
  - SUBC: r = AR - op - CARRY; c=1 on borrow.
  - Computed at DATA_WIDTH+1 bits; r wraps modulo 2^DATA_WIDTH.
  - OV = two's-complement overflow: ADD when operand signs match and result sign differs; SUB when operand signs differ and result sign differs from AR.
  - All four flags updated.
- Logic, IR[1:0]: 00 NOR, 01 NAND, 10 XOR, 11 XNOR. Bitwise on AR and op. CARRY=0, OV=0.
- Shift, IR[1:0]:
  - 00 SHL: C=AR[MSB], LSB in=0.
  - 01 SHR: C=AR[0], MSB in=0.
  - 10 ROLC: rotate left through CARRY.
  - 11 RORC: rotate right through CARRY.
  - OV=0.
- ZERO = (r==0). NEG = r[MSB]. Both updated by every arithmetic, logic, shift and load.
- Loads update ZERO and NEG only; CARRY and OV hold.
- Undefined opcode with Exec=1: AR and Flags hold, err_illegal←1 (sticky until arst), retired not incremented.
- retired: increments by 1 per defined Exec and wraps from all-ones to 0 without error.
- Back-to-back Exec on consecutive cycles is legal. Each is processed using the AR and Flags registered by the previous one.
- Purely synchronous apart from arst. No combinational path from inputs to outputs.

Test Plan:
- Reset with Exec held at 1 and IR=LOAD_I, IBR=8'h55 → AR=0, Flags=0 while arst is high; after release, one Exec → AR=8'h55, Flags=4'b0000.
- LOAD_I 8'h7F, then ADD-imm 8'h01 → AR=8'h80, NEG=1, OV=1, CARRY=0, ZERO=0.
- LOAD_I 8'hFF, ADD-imm 8'h01 → AR=8'h00, ZERO=1, CARRY=1. Then ADDC-imm 8'h00 → AR=8'h01, CARRY=0.
- LOAD_I 8'h10, SUB-mem with MBR=8'h20 → AR=8'hF0, CARRY=1 (borrow), NEG=1. Then SUBC-imm 8'h00 → AR=8'hEF.
- LOAD_I 8'h81, ROLC with CARRY=0 → AR=8'h02, CARRY=1. Then XOR-imm 8'h02 → AR=8'h00, ZERO=1, CARRY=0.
- Exec with IR=8'hFF → AR and Flags unchanged, err_illegal=1, retired unchanged. Force retired to 16'hFFFF, then one defined Exec → retired=0.

Source files
------------

// File: rtl/alu_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : alu_accumulator
//  Brief    : Execution stage. Owns the accumulator AR and the ZERO/CARRY/
//             NEG/OV flags, applies one instruction per Exec strobe, and
//             keeps a sticky illegal-opcode flag plus a retired counter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int INST_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  Exec,
  input  logic [INST_WIDTH-1:0] IR,
  input  logic [DATA_WIDTH-1:0] IBR,
  input  logic [DATA_WIDTH-1:0] MBR,
  output logic [DATA_WIDTH-1:0] AR,
  output logic [3:0]            Flags,
  output logic                  err_illegal,
  output logic [CNT_WIDTH-1:0]  retired
);

  localparam int MSB    = DATA_WIDTH - 1;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Opcode map. Classes carrying a sub-op in IR[1:0] are matched on prefixes.
  localparam logic [7:0] OP_LOAD_X  = 8'b0000_0001;
  localparam logic [7:0] OP_LOAD_I  = 8'b0000_0010;
  localparam logic [7:0] OP_STORE_X = 8'b0000_0101;
  localparam logic [7:0] OP_STORE_I = 8'b0000_0110;
  localparam logic [7:0] OP_JMP     = 8'b0010_0000;
  localparam logic [7:0] OP_JZ      = 8'b0010_0001;
  localparam logic [7:0] OP_JC      = 8'b0010_0010;
  localparam logic [7:0] OP_JN      = 8'b0010_0011;
  localparam logic [7:0] OP_JV      = 8'b0010_0100;
  localparam logic [4:0] PFX_ARITH  = 5'b01000;   // bit 2 selects IBR
  localparam logic [4:0] PFX_LOGIC  = 5'b10000;   // bit 2 selects IBR
  localparam logic [5:0] PFX_SHIFT  = 6'b110000;

  logic [DATA_WIDTH-1:0] ar_q, ar_d;
  logic [3:0]            flags_q, flags_d;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  ret_q;

  logic [7:0]            w_op;
  logic                  w_hi_zero;
  logic                  w_is_load, w_is_arith, w_is_logic, w_is_shift, w_is_nop;
  logic                  w_defined;
  logic [DATA_WIDTH-1:0] w_opnd;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_cin;

  assign w_op = IR[7:0];

  // Opcodes live in the low byte; any set upper bit makes the opcode undefined.
  if (INST_WIDTH > 8) begin : g_ir_wide
    assign w_hi_zero = ~|IR[INST_WIDTH-1:8];
  end else begin : g_ir_exact
    assign w_hi_zero = 1'b1;
  end

  assign w_is_load  = (w_op == OP_LOAD_X) || (w_op == OP_LOAD_I);
  assign w_is_arith = (w_op[7:3] == PFX_ARITH);
  assign w_is_logic = (w_op[7:3] == PFX_LOGIC);
  assign w_is_shift = (w_op[7:2] == PFX_SHIFT);
  assign w_is_nop   = (w_op == OP_STORE_X) || (w_op == OP_STORE_I) ||
                      (w_op == OP_JMP) || (w_op == OP_JZ) || (w_op == OP_JC) ||
                      (w_op == OP_JN) || (w_op == OP_JV);
  assign w_defined  = w_hi_zero &
                      (w_is_load | w_is_arith | w_is_logic | w_is_shift | w_is_nop);

  assign w_opnd = w_op[2] ? IBR : MBR;
  // ADDC/SUBC (IR[1]=1) fold the current CARRY in as carry/borrow.
  assign w_cin  = w_op[1] & flags_q[FLAG_C];

  // Arithmetic at DATA_WIDTH+1 bits; the top bit is carry-out or borrow.
  always_comb begin
    if (w_op[0] == 1'b0)
      w_sum = {1'b0, ar_q} + {1'b0, w_opnd} + (DATA_WIDTH+1)'(w_cin);
    else
      w_sum = {1'b0, ar_q} - {1'b0, w_opnd} - (DATA_WIDTH+1)'(w_cin);
  end

  // Next AR and Flags for the opcode on IR; no-ops leave both unchanged.
  always_comb begin
    ar_d    = ar_q;
    flags_d = flags_q;
    if (w_is_load) begin
      ar_d = (w_op == OP_LOAD_X) ? MBR : IBR;
    end else if (w_is_arith) begin
      ar_d            = w_sum[MSB:0];
      flags_d[FLAG_C] = w_sum[DATA_WIDTH];
      if (w_op[0] == 1'b0)
        flags_d[FLAG_V] = (ar_q[MSB] == w_opnd[MSB]) && (w_sum[MSB] != ar_q[MSB]);
      else
        flags_d[FLAG_V] = (ar_q[MSB] != w_opnd[MSB]) && (w_sum[MSB] != ar_q[MSB]);
    end else if (w_is_logic) begin
      case (w_op[1:0])
        2'b00:   ar_d = ~(ar_q | w_opnd);
        2'b01:   ar_d = ~(ar_q & w_opnd);
        2'b10:   ar_d = ar_q ^ w_opnd;
        default: ar_d = ~(ar_q ^ w_opnd);
      endcase
      flags_d[FLAG_C] = 1'b0;
      flags_d[FLAG_V] = 1'b0;
    end else if (w_is_shift) begin
      case (w_op[1:0])
        2'b00: begin
          ar_d            = {ar_q[MSB-1:0], 1'b0};
          flags_d[FLAG_C] = ar_q[MSB];
        end
        2'b01: begin
          ar_d            = {1'b0, ar_q[MSB:1]};
          flags_d[FLAG_C] = ar_q[0];
        end
        2'b10: begin
          ar_d            = {ar_q[MSB-1:0], flags_q[FLAG_C]};
          flags_d[FLAG_C] = ar_q[MSB];
        end
        default: begin
          ar_d            = {flags_q[FLAG_C], ar_q[MSB:1]};
          flags_d[FLAG_C] = ar_q[0];
        end
      endcase
      flags_d[FLAG_V] = 1'b0;
    end
    // ZERO and NEG follow the result of every data-producing class.
    if (w_is_load || w_is_arith || w_is_logic || w_is_shift) begin
      flags_d[FLAG_Z] = (ar_d == '0);
      flags_d[FLAG_N] = ar_d[MSB];
    end
  end

  // Architectural state: commits only on Exec; undefined opcodes raise the sticky error.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ar_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else if (Exec) begin
      if (w_defined) begin
        ar_q    <= ar_d;
        flags_q <= flags_d;
        ret_q   <= ret_q + 1'b1;
      end else begin
        err_q   <= 1'b1;
      end
    end
  end

  assign AR          = ar_q;
  assign Flags       = flags_q;
  assign err_illegal = err_q;
  assign retired     = ret_q;

endmodule
`default_nettype wire
